// File: rtl/sevenseg_capture_if.sv
// sevenseg_capture_if
// Groups the multiplexed seven-segment display pins that feed the capture
// block together with the decoded frame it produces.
//
// Signals:
//   seg_i[6:0]     multiplexed cathodes, active-low, bit0=a .. bit6=g
//   an_i[3:0]      multiplexed anodes, active-low; an_i[0] drives digit3,
//                  an_i[3] drives digit0
//   dp_i           decimal point, active-low
//   digit0_o..3_o  hex values of the last complete frame
//   decplace_o     anode bit index that was low while dp was low
//   dp_seen_o      a decimal point was seen in the last frame
//   frame_valid_o  one-cycle pulse when the frame outputs update
//   err_o[3:0]     per-digit unrecognised-pattern flags (bit n = digitn)
//   stale_o        no position has been accepted for the timeout period
//
// Modports:
//   slave  - the capture block (reads pins, drives frame outputs)
//   master - the display source / frame consumer
interface sevenseg_capture_if;
    logic [6:0] seg_i;
    logic [3:0] an_i;
    logic       dp_i;
    logic [3:0] digit0_o;
    logic [3:0] digit1_o;
    logic [3:0] digit2_o;
    logic [3:0] digit3_o;
    logic [1:0] decplace_o;
    logic       dp_seen_o;
    logic       frame_valid_o;
    logic [3:0] err_o;
    logic       stale_o;

    modport slave (
        input  seg_i, an_i, dp_i,
        output digit0_o, digit1_o, digit2_o, digit3_o,
        output decplace_o, dp_seen_o, frame_valid_o, err_o, stale_o
    );

    modport master (
        output seg_i, an_i, dp_i,
        input  digit0_o, digit1_o, digit2_o, digit3_o,
        input  decplace_o, dp_seen_o, frame_valid_o, err_o, stale_o
    );
endinterface

// File: rtl/sevenseg_capture.sv
// sevenseg_capture
// Snoops a 4-digit multiplexed seven-segment display and reconstructs the
// displayed hex digits. Each pin is synchronised, a position is accepted
// once its anode/cathode/dp sample has been stable for STABLE_CYCLES, and
// once all four positions have been accepted the frame is published with a
// one-cycle frame_valid_o pulse.
//
// Parameters:
//   STABLE_CYCLES  - identical consecutive samples needed to accept
//   TIMEOUT_CYCLES - idle cycles without acceptance before stale_o asserts
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - sevenseg_capture_if.slave (display pins in, frame out)
//
// Configuration macro:
//   SEVENSEG_CAPTURE_ERR_EN - when defined, unrecognised cathode patterns set
//   the position's err bit and leave its value untouched; when undefined
//   err_o is tied to 0 and unrecognised patterns decode as F.
module sevenseg_capture #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input logic             clk,
    input logic             rst_n,
    sevenseg_capture_if.slave bus
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_ACC = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    // Packed sample layout: {an[3:0], seg[6:0], dp}
    logic [11:0]       sync1_q, sync2_q, prev_q;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    logic [3:0][3:0]   val_q, val_d;
    logic [3:0]        seen_q, seen_d;
    logic [1:0]        decShadow_q, decShadow_d;
    logic              dpShadow_q, dpShadow_d;

    logic [3:0][3:0]   digits_q;
    logic [1:0]        decplace_q;
    logic              dpSeen_q;
    logic              frameValid_q;

    logic [3:0]        sampAn;
    logic [6:0]        sampSeg;
    logic              sampDp;
    logic              anOneLow;
    logic [1:0]        anIdx;
    logic [1:0]        digitIdx;
    logic              accept;
    logic              frameDone;
    logic [3:0]        decVal;

`ifdef SEVENSEG_CAPTURE_ERR_EN
    logic              decOk;
    logic [3:0]        errShadow_q, errShadow_d;
    logic [3:0]        err_q;
`endif

    // The stability counter compares against prev_q, so prev_q is the sample
    // that has been held; acceptance decisions are taken from it.
    assign sampAn  = prev_q[11:8];
    assign sampSeg = prev_q[7:1];
    assign sampDp  = prev_q[0];

    // Two-flop synchronisers plus one-cycle history for the stability check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {bus.an_i, bus.seg_i, bus.dp_i};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Stability counter saturates at STABLE_CYCLES, so it sits on
    // STABLE_CYCLES-1 for a single cycle per stable run and the acceptance
    // fires exactly once however long the pattern is held.
    always_comb begin
        stab_d = '0;
        if (sync2_q == prev_q) begin
            stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
        end
    end

    // Anode decode: exactly one low bit identifies the position; an_i[k]
    // drives digit (3-k), hence the inverted index.
    always_comb begin
        anOneLow = 1'b1;
        anIdx    = 2'd0;
        case (sampAn)
            4'b1110: anIdx = 2'd0;
            4'b1101: anIdx = 2'd1;
            4'b1011: anIdx = 2'd2;
            4'b0111: anIdx = 2'd3;
            default: anOneLow = 1'b0;
        endcase
    end

    assign digitIdx  = ~anIdx;
    assign accept    = (stab_q == STAB_ACC) && anOneLow;
    assign frameDone = &seen_q;

    // Cathode decode (active-low segments, bit0=a).
    always_comb begin
        decVal = 4'hF;
`ifdef SEVENSEG_CAPTURE_ERR_EN
        decOk  = 1'b1;
`endif
        case (sampSeg)
            7'b1000000: decVal = 4'h0;
            7'b1111001: decVal = 4'h1;
            7'b0100100: decVal = 4'h2;
            7'b0110000: decVal = 4'h3;
            7'b0011001: decVal = 4'h4;
            7'b0010010: decVal = 4'h5;
            7'b0000010: decVal = 4'h6;
            7'b1111000: decVal = 4'h7;
            7'b0000000: decVal = 4'h8;
            7'b0010000: decVal = 4'h9;
            7'b0001000: decVal = 4'hA;
            7'b0000011: decVal = 4'hB;
            7'b1000110: decVal = 4'hC;
            7'b0100001: decVal = 4'hD;
            7'b0000110: decVal = 4'hE;
            7'b0001110: decVal = 4'hF;
            default: begin
                decVal = 4'hF;
`ifdef SEVENSEG_CAPTURE_ERR_EN
                decOk  = 1'b0;
`endif
            end
        endcase
    end

    // Shadow update. A completed frame clears the seen/dp bookkeeping first,
    // and an acceptance landing on that same cycle is then applied on top so
    // it becomes the first position of the following frame.
    always_comb begin
        val_d       = val_q;
        decShadow_d = decShadow_q;
        seen_d      = frameDone ? 4'b0000 : seen_q;
        dpShadow_d  = frameDone ? 1'b0 : dpShadow_q;
`ifdef SEVENSEG_CAPTURE_ERR_EN
        errShadow_d = errShadow_q;
`endif
        if (accept) begin
            seen_d[digitIdx] = 1'b1;
`ifdef SEVENSEG_CAPTURE_ERR_EN
            if (decOk) begin
                val_d[digitIdx]       = decVal;
                errShadow_d[digitIdx] = 1'b0;
            end else begin
                errShadow_d[digitIdx] = 1'b1;
            end
`else
            val_d[digitIdx] = decVal;
`endif
            if (!sampDp) begin
                decShadow_d = anIdx;
                dpShadow_d  = 1'b1;
            end
        end
    end

    // Idle counter saturates at the timeout; stale follows it directly.
    always_comb begin
        idle_d = '0;
        if (!accept) begin
            idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;
        end
    end

    // Counters and shadow state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_q      <= '0;
            idle_q      <= '0;
            val_q       <= '0;
            seen_q      <= '0;
            decShadow_q <= '0;
            dpShadow_q  <= 1'b0;
        end else begin
            stab_q      <= stab_d;
            idle_q      <= idle_d;
            val_q       <= val_d;
            seen_q      <= seen_d;
            decShadow_q <= decShadow_d;
            dpShadow_q  <= dpShadow_d;
        end
    end

`ifdef SEVENSEG_CAPTURE_ERR_EN
    // Per-position error shadow and published error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errShadow_q <= '0;
            err_q       <= '0;
        end else begin
            errShadow_q <= errShadow_d;
            if (frameDone) begin
                err_q <= errShadow_q;
            end
        end
    end
`endif

    // Published frame: shadows are copied the cycle after the last position
    // of a frame has been accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q     <= '0;
            decplace_q   <= '0;
            dpSeen_q     <= 1'b0;
            frameValid_q <= 1'b0;
        end else begin
            frameValid_q <= frameDone;
            if (frameDone) begin
                digits_q   <= val_q;
                decplace_q <= decShadow_q;
                dpSeen_q   <= dpShadow_q;
            end
        end
    end

    assign bus.digit0_o      = digits_q[0];
    assign bus.digit1_o      = digits_q[1];
    assign bus.digit2_o      = digits_q[2];
    assign bus.digit3_o      = digits_q[3];
    assign bus.decplace_o    = decplace_q;
    assign bus.dp_seen_o     = dpSeen_q;
    assign bus.frame_valid_o = frameValid_q;
    assign bus.stale_o       = (idle_q == IDLE_MAX);
`ifdef SEVENSEG_CAPTURE_ERR_EN
    assign bus.err_o         = err_q;
`else
    assign bus.err_o         = 4'b0000;
`endif

endmodule

// File: doc/sevenseg_capture.md
SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: consecutive identical synchronised samples needed to accept a position.
REQ-002 Parameter TIMEOUT_CYCLES, default 1048576: cycles without an accepted position before stale asserts.
REQ-003 clk  input  1  single system clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 seg  input  7  multiplexed cathodes, active-low, bit0=a .. bit6=g.
REQ-006 an  input  4  multiplexed anodes, active-low; an[0]->digit3, an[1]->digit2, an[2]->digit1, an[3]->digit0.
REQ-007 dp  input  1  decimal point, active-low.
REQ-008 digit0..digit3  output  4 each  last complete frame, hex values.
REQ-009 decplace  output  2  index of the anode bit that was low while dp was low.
REQ-010 dp_seen  output  1  dp was low on some position in the last frame.
REQ-011 frame_valid  output  1  one-cycle pulse when the outputs update.
REQ-012 err  output  4  per-digit unrecognised-pattern flags for the last frame (bit n = digitn).
REQ-013 stale  output  1  no accepted position for TIMEOUT_CYCLES.

Function
REQ-014 seg, an and dp each pass through a 2-flop synchroniser; all later logic uses only the synchronised values.
REQ-015 Stability counter: it increments while {an,seg,dp} equals the previous cycle's sample, clears to 0 on any change, and saturates.
REQ-016 A sample is accepted exactly once, on the cycle the counter reaches STABLE_CYCLES-1, and only if an has exactly one bit low.
REQ-017 an=4'b1111 or multiple low bits: no acceptance, no state change besides the counters.
REQ-018 Decode table (seg to value): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0001000->A, 0000011->b, 1000110->C, 0100001->d, 0000110->E, 0001110->F.
REQ-019 Acceptance writes the decoded value into a shadow register for that position and sets its seen bit.
REQ-020 Acceptance with dp=0 records decplace_shadow = index of the low an bit and sets dp_shadow; if several positions show dp in one frame, the last one wins.
REQ-021 When all four seen bits are set after an acceptance, on the next cycle: shadows copy to the outputs, frame_valid=1, seen bits and dp_shadow clear.
REQ-022 A position accepted twice before the frame completes overwrites its shadow; the frame still needs all four positions.
REQ-023 If the frame-completing acceptance coincides with a new acceptance, the completing frame is output first; the new sample starts the next frame.
REQ-024 Idle counter: it clears on every acceptance, increments otherwise, and saturates at TIMEOUT_CYCLES.
REQ-025 stale=1 while the idle counter equals TIMEOUT_CYCLES, and clears on the cycle after the next acceptance.
REQ-026 stale asserting does not alter the outputs or the seen bits.
REQ-027 Latency: from the input pins to frame_valid is 2 (sync) + STABLE_CYCLES + 1 cycles after the last position's stable start.

Reset
REQ-028 While rst_n=0 (asynchronous): synchronisers and shadows are 0, digit0..3=0, decplace=0, dp_seen=0, frame_valid=0, err=0, stale=0, all counters 0, seen bits 0.
REQ-029 Reset mid-frame discards partial shadows; the first frame after reset needs all four positions again.

Configuration
REQ-030 Macro SEVENSEG_CAPTURE_ERR_EN defined: a pattern not in REQ-018 sets that position's err shadow bit, leaves its value shadow unchanged, and still sets the seen bit; err updates with the frame.
REQ-031 Macro SEVENSEG_CAPTURE_ERR_EN undefined: err is constant 0, and an unrecognised pattern decodes as F.

Verification
REQ-032 Drive 1,2,3,4 on an[3..0] low in turn, each held 64 cycles -> a single frame_valid with digit0=1, digit1=2, digit2=3, digit3=4, dp_seen=0.
REQ-033 Same frame plus dp=0 while an=1101 -> decplace=1, dp_seen=1.
REQ-034 Glitch: seg changes for 5 cycles inside a 64-cycle hold -> still exactly one acceptance; the value is that of the final stable pattern.
REQ-035 Pattern 1111111 on digit2 -> with macro: err=4'b0100 and digit2 keeps its previous value; without macro: digit2=F and err=0.
REQ-036 TIMEOUT_CYCLES=100 and an held at 1111 for 120 cycles -> stale=1 at idle count 100; a new acceptance clears it; the outputs are unchanged.
REQ-037 rst_n low for 3 cycles after 3 of 4 positions -> all outputs 0; the next frame_valid only after 4 new positions.
